// File: rtl/ram4k_port_arbiter.sv
// ram4k_port_arbiter
//
// Shares the single read/write port of a 4k x 8 synchronous block RAM
// between two bus requesters (m0, m1). It can also run a clear sweep that
// writes FILL to every address, either after reset or when init_req pulses.
// All RAM-side outputs are registered. The RAM is assumed to have a
// one-cycle registered read.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   init_req              one-cycle pulse requesting a clear sweep
//   busy                  high while a clear sweep is running or pending
//   mX_cyc/we/adr/dat_i   requester X request, held until mX_ack
//   mX_dat_o              requester X read data, valid while mX_ack is high
//   mX_ack                requester X one-cycle acknowledge
//   ram_ce/we/adr/dat_o   registered RAM port strobes, address and write data
//   ram_dat_i             RAM read data, valid the cycle after ram_ce
module ram4k_port_arbiter #(
  parameter int              AW            = 12,
  parameter int              DW            = 8,
  parameter bit              INIT_ON_RESET = 1'b1,
  parameter logic [DW-1:0]   FILL          = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  output logic          busy,
  input  logic          m0_cyc,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack,
  input  logic          m1_cyc,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_dat_o,
  input  logic [DW-1:0] ram_dat_i
);

  localparam logic [2:0] ST_CLEAR  = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  localparam logic [2:0]    ST_RESET = INIT_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [AW-1:0] ADR_LAST = '1;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_m1_q, last_m1_d;
  logic          sel_m1_q, sel_m1_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          ram_ce_q, ram_ce_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_adr_q, ram_adr_d;
  logic [DW-1:0] ram_wdat_q, ram_wdat_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdat_q, m0_rdat_d;
  logic [DW-1:0] m1_rdat_q, m1_rdat_d;
  logic          grant_m1;

  // Next-state logic. CLEAR knows the sweep is finished when the previous
  // edge strobed the last address, which avoids a wider counter. In IDLE a
  // new or pending clear request beats any bus request. On a tie the
  // requester that was not served last wins, so continuous requests from
  // both sides alternate; last_m1 resets to 1 so m0 wins the first tie.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_m1_d  = last_m1_q;
    sel_m1_d   = sel_m1_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    ram_ce_d   = ram_ce_q;
    ram_we_d   = ram_we_q;
    ram_adr_d  = ram_adr_q;
    ram_wdat_d = ram_wdat_q;
    m0_ack_d   = m0_ack_q;
    m1_ack_d   = m1_ack_q;
    m0_rdat_d  = m0_rdat_q;
    m1_rdat_d  = m1_rdat_q;
    grant_m1   = m1_cyc && (!m0_cyc || !last_m1_q);

    case (state_q)
      ST_CLEAR: begin
        if (ram_ce_q && (ram_adr_q == ADR_LAST)) begin
          ram_ce_d = 1'b0;
          ram_we_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          ram_ce_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_adr_d  = cnt_q;
          ram_wdat_d = FILL;
          cnt_d      = cnt_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (init_req || pend_q) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end else if (m0_cyc || m1_cyc) begin
          sel_m1_d   = grant_m1;
          last_m1_d  = grant_m1;
          ram_ce_d   = 1'b1;
          ram_we_d   = grant_m1 ? m1_we    : m0_we;
          ram_adr_d  = grant_m1 ? m1_adr   : m0_adr;
          ram_wdat_d = grant_m1 ? m1_dat_i : m0_dat_i;
          state_d    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        ram_ce_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = ST_DATA;
      end

      ST_DATA: begin
        if (sel_m1_q) begin
          m1_rdat_d = ram_dat_i;
          m1_ack_d  = 1'b1;
        end else begin
          m0_rdat_d = ram_dat_i;
          m0_ack_d  = 1'b1;
        end
        state_d = ST_ACK;
      end

      ST_ACK: begin
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear request arriving mid-access is remembered and started from
    // IDLE once the running access has been acknowledged.
    if ((state_q == ST_ACCESS || state_q == ST_DATA || state_q == ST_ACK) && init_req) begin
      pend_d = 1'b1;
      busy_d = 1'b1;
    end
  end

  // State registers; reset drops every strobe and acknowledge at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      last_m1_q  <= 1'b1;
      sel_m1_q   <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= INIT_ON_RESET;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_adr_q  <= '0;
      ram_wdat_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdat_q  <= '0;
      m1_rdat_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_m1_q  <= last_m1_d;
      sel_m1_q   <= sel_m1_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      ram_ce_q   <= ram_ce_d;
      ram_we_q   <= ram_we_d;
      ram_adr_q  <= ram_adr_d;
      ram_wdat_q <= ram_wdat_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdat_q  <= m0_rdat_d;
      m1_rdat_q  <= m1_rdat_d;
    end
  end

  assign busy      = busy_q;
  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_adr   = ram_adr_q;
  assign ram_dat_o = ram_wdat_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_dat_o  = m0_rdat_q;
  assign m1_dat_o  = m1_rdat_q;

endmodule

// File: tb/tb_ram4k_port_arbiter.sv
// tb_ram4k_port_arbiter
//
// Self-checking bench for ram4k_port_arbiter (AW=12, FILL=8'hA5, clear on
// reset). A behavioural RAM sits on the RAM port. A transaction-level model
// predicts, per clock edge, the RAM strobes, busy, acknowledges and read
// data from the access schedule (sweep windows, 4-cycle accesses, tie
// alternation, shadow memory); one process compares the DUT to it every
// cycle, and directed scenarios add literal expectations.
module tb_ram4k_port_arbiter;

  localparam int          SWEEP_LEN   = 4096;
  localparam logic [7:0]  FILL_VALUE  = 8'hA5;
  localparam int          KIND_IDLE   = 0;
  localparam int          KIND_SWEEP  = 1;
  localparam int          KIND_ACCESS = 2;
  localparam int          RAND_N      = 120;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        initReq = 1'b0;
  logic        busy;
  logic        m0Cyc = 1'b0, m0We = 1'b0;
  logic [11:0] m0Adr = '0;
  logic [7:0]  m0DatI = '0;
  logic [7:0]  m0DatO;
  logic        m0Ack;
  logic        m1Cyc = 1'b0, m1We = 1'b0;
  logic [11:0] m1Adr = '0;
  logic [7:0]  m1DatI = '0;
  logic [7:0]  m1DatO;
  logic        m1Ack;
  logic        ramCe, ramWe;
  logic [11:0] ramAdr;
  logic [7:0]  ramDatO;
  logic [7:0]  ramDatI = '0;
  logic [7:0]  ramMem [SWEEP_LEN];

  int checks = 0;
  int failures = 0;

  int          edgeNo, nextDecision, sweepFirst, accStart, accWho, lastWho, actKind;
  bit          pendInit, accWe;
  logic [11:0] accAdr;
  logic [7:0]  accDat, accRead;
  logic [7:0]  shadow [SWEEP_LEN];
  bit          expCe, expWe, expBusy, expAck0, expAck1, rdKnown0, rdKnown1;
  logic [11:0] expAdr;
  logic [7:0]  expWdat, expRd0, expRd1;

  logic [7:0]  rd0, rd1;
  int          wait0, wait1, guardA, guardB, ceCount;
  bit          inOrder;
  int          ackLogWho[$];
  int          ackLogEdge[$];

  ram4k_port_arbiter #(
    .AW(12), .DW(8), .INIT_ON_RESET(1'b1), .FILL(FILL_VALUE)
  ) dut (
    .clk(clk), .rst_n(rstN), .init_req(initReq), .busy(busy),
    .m0_cyc(m0Cyc), .m0_we(m0We), .m0_adr(m0Adr), .m0_dat_i(m0DatI),
    .m0_dat_o(m0DatO), .m0_ack(m0Ack),
    .m1_cyc(m1Cyc), .m1_we(m1We), .m1_adr(m1Adr), .m1_dat_i(m1DatI),
    .m1_dat_o(m1DatO), .m1_ack(m1Ack),
    .ram_ce(ramCe), .ram_we(ramWe), .ram_adr(ramAdr), .ram_dat_o(ramDatO),
    .ram_dat_i(ramDatI)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Behavioural block RAM with a one-cycle registered, read-first port.
  always @(posedge clk) begin
    if (ramCe) begin
      if (ramWe) ramMem[ramAdr] <= ramDatO;
      ramDatI <= ramMem[ramAdr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, actual, required, $time);
    end
  endtask

  task automatic fillShadow();
    for (int a = 0; a < SWEEP_LEN; a++) shadow[a] = FILL_VALUE;
  endtask

  // Model reset: a sweep whose first write lands on edge 1 after release.
  task automatic modelReset();
    edgeNo = 0;
    actKind = KIND_SWEEP;
    sweepFirst = 1;
    nextDecision = sweepFirst + SWEEP_LEN + 1;
    pendInit = 1'b0;
    lastWho = 1;
    expCe = 1'b0; expWe = 1'b0; expBusy = 1'b1;
    expAck0 = 1'b0; expAck1 = 1'b0;
    expAdr = '0; expWdat = '0;
    expRd0 = '0; expRd1 = '0; rdKnown0 = 1'b1; rdKnown1 = 1'b1;
    fillShadow();
  endtask

  // Reference model: at every edge, decide (when the arbiter is free) what
  // activity starts, then derive the outputs from the edge's offset inside
  // the current activity's window.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        modelReset();
      end else begin
        edgeNo++;
        if (edgeNo == nextDecision) begin
          if (pendInit || initReq) begin
            actKind = KIND_SWEEP;
            sweepFirst = edgeNo + 1;
            nextDecision = sweepFirst + SWEEP_LEN + 1;
            pendInit = 1'b0;
            fillShadow();
          end else if (m0Cyc || m1Cyc) begin
            if (m0Cyc && m1Cyc) accWho = 1 - lastWho;
            else accWho = m1Cyc ? 1 : 0;
            lastWho = accWho;
            accWe   = (accWho == 1) ? m1We   : m0We;
            accAdr  = (accWho == 1) ? m1Adr  : m0Adr;
            accDat  = (accWho == 1) ? m1DatI : m0DatI;
            accRead = shadow[accAdr];
            if (accWe) shadow[accAdr] = accDat;
            actKind = KIND_ACCESS;
            accStart = edgeNo;
            nextDecision = edgeNo + 4;
          end else begin
            actKind = KIND_IDLE;
            nextDecision = edgeNo + 1;
          end
        end else if (actKind == KIND_ACCESS && initReq) begin
          pendInit = 1'b1;
        end

        expCe = 1'b0; expWe = 1'b0; expAck0 = 1'b0; expAck1 = 1'b0;
        expBusy = pendInit;
        if (actKind == KIND_SWEEP) begin
          if (edgeNo < sweepFirst + SWEEP_LEN) expBusy = 1'b1;
          if (edgeNo >= sweepFirst && edgeNo < sweepFirst + SWEEP_LEN) begin
            expCe = 1'b1; expWe = 1'b1;
            expAdr = 12'(edgeNo - sweepFirst);
            expWdat = FILL_VALUE;
          end
        end else if (actKind == KIND_ACCESS) begin
          if (edgeNo == accStart) begin
            expCe = 1'b1; expWe = accWe; expAdr = accAdr; expWdat = accDat;
          end
          if (edgeNo == accStart + 2) begin
            if (accWho == 0) begin
              expAck0 = 1'b1; rdKnown0 = !accWe; expRd0 = accRead;
            end else begin
              expAck1 = 1'b1; rdKnown1 = !accWe; expRd1 = accRead;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("ram_ce", 32'(ramCe), 32'(expCe));
      checkOutput("ram_we", 32'(ramWe), 32'(expWe));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("m0_ack", 32'(m0Ack), 32'(expAck0));
      checkOutput("m1_ack", 32'(m1Ack), 32'(expAck1));
      if (expCe) begin
        checkOutput("ram_adr", 32'(ramAdr), 32'(expAdr));
        checkOutput("ram_dat_o", 32'(ramDatO), 32'(expWdat));
      end
      if (rdKnown0) checkOutput("m0_dat_o", 32'(m0DatO), 32'(expRd0));
      if (rdKnown1) checkOutput("m1_dat_o", 32'(m1DatO), 32'(expRd1));
    end
  end

  // Drives one request for requester m starting at the current falling edge
  // and waits (bounded) for its ack; cyc is left high so the caller can
  // either present the next request or release it.
  task automatic applyStimulus(input int m, input bit we, input logic [11:0] adr,
                               input logic [7:0] dat, input int limit,
                               output logic [7:0] rdat, output int waited);
    bit gotAck;
    if (m == 0) begin
      m0Cyc = 1'b1; m0We = we; m0Adr = adr; m0DatI = dat;
    end else begin
      m1Cyc = 1'b1; m1We = we; m1Adr = adr; m1DatI = dat;
    end
    waited = 0;
    gotAck = 1'b0;
    while (!gotAck && waited < limit) begin
      @(negedge clk);
      waited++;
      gotAck = (m == 0) ? (m0Ack === 1'b1) : (m1Ack === 1'b1);
    end
    checkOutput((m == 0) ? "ackSeenM0" : "ackSeenM1", 32'(gotAck), 32'd1);
    rdat = (m == 0) ? m0DatO : m1DatO;
  endtask

  task automatic releaseMaster(input int m);
    if (m == 0) m0Cyc = 1'b0;
    else m1Cyc = 1'b0;
  endtask

  task automatic waitSweepDone(input string name);
    int g;
    g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  // Hard stop in case something blocks forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetRamCe", 32'(ramCe), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd1);
    checkOutput("resetAcks", 32'({m0Ack, m1Ack}), 32'd0);
    checkOutput("resetDatO", 32'({m0DatO, m1DatO}), 32'd0);

    // Reset sweep: 4096 consecutive writes in address order, busy drops next.
    rstN = 1'b1;
    ceCount = 0; inOrder = 1'b1; guardA = 0;
    while (busy && guardA < 5000) begin
      @(negedge clk);
      guardA++;
      if (ramCe) begin
        if (ramAdr !== 12'(ceCount)) inOrder = 1'b0;
        ceCount++;
      end
    end
    checkOutput("sweepLength", 32'(ceCount), 32'd4096);
    checkOutput("sweepOrder", 32'(inOrder), 32'd1);

    // Both requesters hold cyc for 4 accesses each: strict alternation.
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          applyStimulus(0, 1'b1, 12'(16 + k), 8'(8'h10 + k), 20, rd0, wait0);
          ackLogWho.push_back(0); ackLogEdge.push_back(edgeNo);
        end
        releaseMaster(0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          applyStimulus(1, 1'b1, 12'(32 + k), 8'(8'h20 + k), 20, rd1, wait1);
          ackLogWho.push_back(1); ackLogEdge.push_back(edgeNo);
        end
        releaseMaster(1);
      end
    join
    checkOutput("tieAckCount", 32'(ackLogWho.size()), 32'd8);
    for (int i = 0; i < ackLogWho.size(); i++) begin
      checkOutput("tieGrantOrder", 32'(ackLogWho[i]), 32'(i % 2));
      if (i > 0) checkOutput("tieAckSpacing", 32'(ackLogEdge[i] - ackLogEdge[i-1]), 32'd4);
    end

    // m0 writes 8'h3C to 12'h123, then reads it back.
    @(negedge clk);
    applyStimulus(0, 1'b1, 12'h123, 8'h3C, 20, rd0, wait0);
    checkOutput("writeAckLatency", 32'(wait0), 32'd3);
    releaseMaster(0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 12'h123, 8'h00, 20, rd0, wait0);
    checkOutput("readAckLatency", 32'(wait0), 32'd3);
    checkOutput("readBack3C", 32'(rd0), 32'h3C);
    releaseMaster(0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 12'h7FF, 8'h00, 20, rd0, wait0);
    checkOutput("readFill7FF", 32'(rd0), 32'hA5);
    releaseMaster(0);

    // init_req during an m1 read: the read completes, then the sweep runs.
    @(negedge clk);
    applyStimulus(1, 1'b1, 12'h456, 8'h5A, 20, rd1, wait1);
    releaseMaster(1);
    @(negedge clk);
    fork
      begin
        applyStimulus(1, 1'b0, 12'h456, 8'h00, 20, rd1, wait1);
        releaseMaster(1);
      end
      begin
        guardB = 0;
        while (!ramCe && guardB < 20) begin
          @(negedge clk);
          guardB++;
        end
        initReq = 1'b1;
        @(negedge clk);
        initReq = 1'b0;
      end
    join
    checkOutput("initReadData", 32'(rd1), 32'h5A);
    checkOutput("initBusyAtAck", 32'(busy), 32'd1);
    waitSweepDone("initSweepEnds");

    // Randomised traffic from both requesters over a small address window.
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < RAND_N; k++) begin
          applyStimulus(0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)),
                        8'($urandom), 20, rd0, wait0);
          if ($urandom_range(0, 3) == 0) begin
            releaseMaster(0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
        releaseMaster(0);
      end
      begin
        for (int k = 0; k < RAND_N; k++) begin
          applyStimulus(1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)),
                        8'($urandom), 20, rd1, wait1);
          if ($urandom_range(0, 3) == 0) begin
            releaseMaster(1);
            repeat ($urandom_range(1, 4)) @(negedge clk);
          end
        end
        releaseMaster(1);
      end
    join

    // Reset pulse during ACCESS: strobes drop at once, sweep restarts, and
    // the still-held request is served after it (sweep refilled 12'h123).
    @(negedge clk);
    @(negedge clk);
    fork
      begin
        applyStimulus(0, 1'b0, 12'h123, 8'h00, 6000, rd0, wait0);
        releaseMaster(0);
      end
      begin
        guardB = 0;
        while (!ramCe && guardB < 20) begin
          @(negedge clk);
          guardB++;
        end
        #2 rstN = 1'b0;
        #1;
        checkOutput("asyncResetRamCe", 32'(ramCe), 32'd0);
        checkOutput("asyncResetAcks", 32'({m0Ack, m1Ack}), 32'd0);
        checkOutput("asyncResetBusy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
      end
    join
    checkOutput("resumedReadData", 32'(rd0), 32'hA5);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
